// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for an iterative barrel shifter.
// Accepts one operation at a time, issues it to the shifter, waits for
// completion (with a hang timeout) and returns the result to the owner.
module shift_arbiter #(
  parameter int unsigned TIMEOUT = 48
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req_valid_0,
  input  logic        req_valid_1,
  output logic        req_ready_0,
  output logic        req_ready_1,
  input  logic [31:0] req_data_0,
  input  logic [31:0] req_data_1,
  input  logic [4:0]  req_amt_0,
  input  logic [4:0]  req_amt_1,
  input  logic [1:0]  req_mode_0,
  input  logic [1:0]  req_mode_1,

  output logic        rsp_valid_0,
  output logic        rsp_valid_1,
  input  logic        rsp_ready_0,
  input  logic        rsp_ready_1,
  output logic [31:0] rsp_data,
  output logic        rsp_err,

  output logic        shf_start,
  output logic [31:0] shf_data_in,
  output logic [4:0]  shf_amount,
  output logic [1:0]  shf_mode,
  input  logic [31:0] shf_data_out,
  input  logic        shf_done,

  output logic        busy,
  output logic        grant_id
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [MODE_W-1:0] MODE_ILLEGAL = 2'b11;
  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
    logic [MODE_W-1:0] mode;
  } op_t;

  state_t             state_q;
  state_t             state_d;
  logic               rr_ptr_q;
  logic               grant_q;
  op_t                op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               rsp_err_q;

  logic               any_req;
  logic               pick;
  op_t                pick_op;
  logic               pick_illegal;
  logic               grant_fire;
  logic               wait_first;
  logic               done_hit;
  logic               timeout_hit;
  logic               rsp_fire;

  // Choose the requester to serve; the pointer only breaks ties
  always_comb begin
    any_req      = req_valid_0 | req_valid_1;
    pick         = 1'b0;
    pick_op      = '0;
    if (req_valid_0 && req_valid_1) begin
      pick = rr_ptr_q;
    end else begin
      pick = req_valid_1;
    end
    if (pick) begin
      pick_op.data = req_data_1;
      pick_op.amt  = req_amt_1;
      pick_op.mode = req_mode_1;
    end else begin
      pick_op.data = req_data_0;
      pick_op.amt  = req_amt_0;
      pick_op.mode = req_mode_0;
    end
    pick_illegal = (pick_op.mode == MODE_ILLEGAL);
  end

  // Event decode shared by the FSM and the datapath registers
  always_comb begin
    grant_fire  = (state_q == S_IDLE) && any_req;
    wait_first  = (cnt_q == '0);
    done_hit    = (state_q == S_WAIT) && !wait_first && shf_done;
    timeout_hit = (state_q == S_WAIT) && (cnt_q == CNT_LAST);
    rsp_fire    = (state_q == S_RESP) && (grant_q ? rsp_ready_1 : rsp_ready_0);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a done seen on the timeout cycle still wins
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = pick_illegal ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_hit || timeout_hit) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_fire) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM outputs: accept pulse is combinational from IDLE, the rest decode state
  always_comb begin
    req_ready_0 = 1'b0;
    req_ready_1 = 1'b0;
    rsp_valid_0 = 1'b0;
    rsp_valid_1 = 1'b0;
    shf_start   = 1'b0;
    busy        = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (rst_n && any_req) begin
          req_ready_0 = !pick;
          req_ready_1 = pick;
        end
      end
      S_ISSUE: begin
        shf_start = 1'b1;
      end
      S_RESP: begin
        rsp_valid_0 = !grant_q;
        rsp_valid_1 = grant_q;
      end
      default: begin
        shf_start = 1'b0;
      end
    endcase
  end

  // Latch the granted operation and its owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      grant_q <= 1'b0;
    end else if (grant_fire) begin
      op_q    <= pick_op;
      grant_q <= pick;
    end
  end

  // Round-robin pointer moves past the requester that just finished
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else if (rsp_fire) begin
      rr_ptr_q <= !grant_q;
    end
  end

  // WAIT cycle counter, zeroed while issuing so WAIT always starts at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == S_ISSUE) begin
      cnt_q <= '0;
    end else if ((state_q == S_WAIT) && !done_hit && !timeout_hit) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Response payload, held stable through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (grant_fire && pick_illegal) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b1;
    end else if (done_hit) begin
      rsp_data_q <= shf_data_out;
      rsp_err_q  <= 1'b0;
    end else if (timeout_hit) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b1;
    end
  end

  assign shf_data_in = op_q.data;
  assign shf_amount  = op_q.amt;
  assign shf_mode    = op_q.mode;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign grant_id    = grant_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios with literal
// expectations plus a randomized run against a transaction-level model.
module tb_shift_arbiter;

  localparam int unsigned TMO = 48;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
  logic        req_ready_0, req_ready_1;
  logic [31:0] req_data_0 = '0, req_data_1 = '0;
  logic [4:0]  req_amt_0 = '0, req_amt_1 = '0;
  logic [1:0]  req_mode_0 = '0, req_mode_1 = '0;
  logic        rsp_valid_0, rsp_valid_1;
  logic        rsp_ready_0 = 1'b1, rsp_ready_1 = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        shf_start;
  logic [31:0] shf_data_in;
  logic [4:0]  shf_amount;
  logic [1:0]  shf_mode;
  logic [31:0] shf_data_out = '0;
  logic        shf_done = 1'b0;
  logic        busy;
  logic        grant_id;

  always #5 clk = ~clk;

  shift_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_data_0(req_data_0), .req_data_1(req_data_1),
    .req_amt_0(req_amt_0), .req_amt_1(req_amt_1),
    .req_mode_0(req_mode_0), .req_mode_1(req_mode_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .shf_start(shf_start), .shf_data_in(shf_data_in),
    .shf_amount(shf_amount), .shf_mode(shf_mode),
    .shf_data_out(shf_data_out), .shf_done(shf_done),
    .busy(busy), .grant_id(grant_id)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Transaction-level model: one outstanding op with timestamps
  bit          m_active = 1'b0, m_legal = 1'b0, m_res = 1'b0;
  bit          m_rr = 1'b0, m_id = 1'b0, m_gid = 1'b0, m_rerr = 1'b0;
  int          m_g = -100, m_resp = 0;
  logic [31:0] m_rdata = '0, m_data = '0;
  logic [4:0]  m_amt = '0;
  logic [1:0]  m_mode = '0;
  bit          acc0 = 1'b0, acc1 = 1'b0;

  // Shifter behaviour plan for the current op
  int p_lat = 3;
  bit p_hang = 1'b0, p_stale = 1'b0, p_auto = 1'b0, p_noise = 1'b0;
  int cur_g = -1, cur_lat = 3;
  bit cur_hang = 1'b0, cur_stale = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] a,
                                            input logic [1:0] m);
    logic signed [31:0] s;
    s = $signed(d);
    case (m)
      2'd0:    return d << a;
      2'd1:    return d >> a;
      default: return 32'(s >>> a);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic model_cycle();
    bit both, any, sel, e_rv0, e_rv1, e_st;
    both  = req_valid_0 && req_valid_1;
    any   = req_valid_0 || req_valid_1;
    sel   = both ? m_rr : req_valid_1;
    e_st  = m_active && m_legal && (cyc == m_g + 1);
    e_rv0 = m_active && m_res && (cyc >= m_resp) && !m_id;
    e_rv1 = m_active && m_res && (cyc >= m_resp) && m_id;
    chkb("req_ready_0", req_ready_0, !m_active && any && !sel);
    chkb("req_ready_1", req_ready_1, !m_active && any && sel);
    chkb("busy", busy, m_active);
    chkb("shf_start", shf_start, e_st);
    chkb("rsp_valid_0", rsp_valid_0, e_rv0);
    chkb("rsp_valid_1", rsp_valid_1, e_rv1);
    chkb("grant_id", grant_id, m_gid);
    chk("shf_data_in", shf_data_in, m_data);
    chk("shf_amount", 32'(shf_amount), 32'(m_amt));
    chk("shf_mode", 32'(shf_mode), 32'(m_mode));
    if (e_rv0 || e_rv1) begin
      chk("rsp_data", rsp_data, m_rdata);
      chkb("rsp_err", rsp_err, m_rerr);
    end
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!m_active) begin
      if (any) begin
        m_active = 1'b1;
        m_g      = cyc;
        m_id     = sel;
        m_gid    = sel;
        m_data   = sel ? req_data_1 : req_data_0;
        m_amt    = sel ? req_amt_1 : req_amt_0;
        m_mode   = sel ? req_mode_1 : req_mode_0;
        m_legal  = (m_mode != 2'b11);
        m_res    = !m_legal;
        m_resp   = cyc + 1;
        m_rdata  = '0;
        m_rerr   = !m_legal;
        if (sel) acc1 = 1'b1; else acc0 = 1'b1;
      end
    end else if (!m_res) begin
      if ((cyc >= m_g + 3) && (shf_done === 1'b1)) begin
        m_res = 1'b1; m_resp = cyc + 1; m_rdata = shf_data_out; m_rerr = 1'b0;
      end else if (cyc == m_g + 1 + int'(TMO)) begin
        m_res = 1'b1; m_resp = cyc + 1; m_rdata = '0; m_rerr = 1'b1;
      end
    end else if ((cyc >= m_resp) && (m_id ? rsp_ready_1 : rsp_ready_0)) begin
      m_active = 1'b0;
      m_rr     = !m_id;
    end
  endtask

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst_n) begin
        chkb("rst_req_ready_0", req_ready_0, 1'b0);
        chkb("rst_req_ready_1", req_ready_1, 1'b0);
        chkb("rst_rsp_valid_0", rsp_valid_0, 1'b0);
        chkb("rst_rsp_valid_1", rsp_valid_1, 1'b0);
        chkb("rst_shf_start", shf_start, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_rsp_err", rsp_err, 1'b0);
        chkb("rst_grant_id", grant_id, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_shf_data_in", shf_data_in, 32'h0);
        chk("rst_shf_amt_mode", 32'({shf_amount, shf_mode}), 32'h0);
        m_active = 1'b0; m_rr = 1'b0; m_gid = 1'b0;
        m_data = '0; m_amt = '0; m_mode = '0;
        acc0 = 1'b0; acc1 = 1'b0;
      end else begin
        model_cycle();
      end
    end
  end

  task automatic drive_shifter();
    if (m_active && m_legal && (m_g != cur_g)) begin
      cur_g = m_g;
      if (p_auto) begin
        cur_lat   = $urandom_range(1, 8);
        cur_hang  = ($urandom % 12 == 0);
        cur_stale = ($urandom % 5 == 0);
      end else begin
        cur_lat = p_lat; cur_hang = p_hang; cur_stale = p_stale;
      end
    end
    shf_done     = 1'b0;
    shf_data_out = $urandom;
    if (m_active && m_legal && !m_res) begin
      if (cur_stale && ((cyc == m_g + 1) || (cyc == m_g + 2))) begin
        shf_done = 1'b1;
        shf_data_out = 32'h1234_5678;
      end else if (!cur_hang && (cyc == m_g + 2 + cur_lat)) begin
        shf_done = 1'b1;
        shf_data_out = ref_shift(m_data, m_amt, m_mode);
      end
    end else if (p_noise) begin
      shf_done = ($urandom % 4 == 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_shifter();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && m_active; k++) step();
    chkb("wait_idle_bound", m_active, 1'b0);
    step();
  endtask

  function automatic logic [1:0] rnd_mode();
    if ($urandom % 8 == 0) return 2'b11;
    return 2'($urandom_range(0, 2));
  endfunction

  int g;
  int gq[$];
  int exp_gr[6] = '{0, 1, 0, 1, 0, 1};
  bit saw;

  initial begin
    rst_n = 1'b0;
    #1;
    chk_en = 1'b1;
    chkb("reset_busy", busy, 1'b0);
    chk("reset_rsp_data", rsp_data, 32'h0);
    step(); step(); step();
    rst_n = 1'b1;

    // Round-robin alternation with both requesters held valid
    p_auto = 1'b0; p_lat = 2; p_hang = 1'b0; p_stale = 1'b0;
    req_data_0 = 32'h0000_0011; req_amt_0 = 5'd1; req_mode_0 = 2'b00;
    req_data_1 = 32'h8000_0100; req_amt_1 = 5'd2; req_mode_1 = 2'b10;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    for (int k = 0; k < 400; k++) begin
      #1;
      if (req_ready_0 === 1'b1) gq.push_back(0);
      if (req_ready_1 === 1'b1) gq.push_back(1);
      if (gq.size() >= 6) break;
      step();
    end
    step();
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    chk("r035_grant_count", 32'(gq.size()), 32'd6);
    for (int i = 0; i < gq.size() && i < 6; i++) chk("r035_grant_order", 32'(gq[i]), 32'(exp_gr[i]));
    wait_idle();

    // Single SLL, 5-cycle shifter
    req_data_0 = 32'h0000_00F0; req_amt_0 = 5'd4; req_mode_0 = 2'b00;
    p_lat = 5; req_valid_0 = 1'b1;
    #1;
    chkb("r034_req_ready", req_ready_0, 1'b1);
    g = cyc;
    step();
    req_valid_0 = 1'b0;
    while (cyc < g + 7) step();
    chkb("r034_not_early", rsp_valid_0, 1'b0);
    step();
    chkb("r034_rsp_valid", rsp_valid_0, 1'b1);
    chk("r034_rsp_data", rsp_data, 32'h0000_0F00);
    chkb("r034_rsp_err", rsp_err, 1'b0);
    wait_idle();

    // Illegal mode answered directly
    req_data_1 = 32'hCAFE_F00D; req_amt_1 = 5'd3; req_mode_1 = 2'b11;
    req_valid_1 = 1'b1;
    #1;
    chkb("r036_req_ready", req_ready_1, 1'b1);
    g = cyc;
    step();
    req_valid_1 = 1'b0;
    chkb("r036_no_start", shf_start, 1'b0);
    chkb("r036_rsp_valid", rsp_valid_1, 1'b1);
    chkb("r036_rsp_err", rsp_err, 1'b1);
    chk("r036_rsp_data", rsp_data, 32'h0);
    wait_idle();

    // Hung shifter hits the timeout, then a new request is accepted
    p_hang = 1'b1;
    req_data_0 = 32'h0000_0001; req_amt_0 = 5'd1; req_mode_0 = 2'b00;
    req_valid_0 = 1'b1;
    #1;
    g = cyc;
    step();
    req_valid_0 = 1'b0;
    p_hang = 1'b0; p_lat = 3;
    while (cyc < g + 49) step();
    chkb("r037_not_early", rsp_valid_0, 1'b0);
    step();
    chkb("r037_rsp_valid", rsp_valid_0, 1'b1);
    chkb("r037_rsp_err", rsp_err, 1'b1);
    chk("r037_rsp_data", rsp_data, 32'h0);
    step();
    req_data_1 = 32'h0000_0F0F; req_amt_1 = 5'd4; req_mode_1 = 2'b01;
    req_valid_1 = 1'b1;
    #1;
    chkb("r037_new_accept", req_ready_1, 1'b1);
    step();
    req_valid_1 = 1'b0;
    wait_idle();

    // Stale done through ISSUE and the first WAIT cycle
    p_stale = 1'b1; p_lat = 4;
    req_data_0 = 32'h8000_0000; req_amt_0 = 5'd3; req_mode_0 = 2'b10;
    req_valid_0 = 1'b1;
    #1;
    g = cyc;
    step();
    req_valid_0 = 1'b0;
    p_stale = 1'b0;
    while (cyc < g + 3) step();
    chkb("r038_stale_ignored", rsp_valid_0, 1'b0);
    while (cyc < g + 7) step();
    chkb("r038_rsp_valid", rsp_valid_0, 1'b1);
    chk("r038_rsp_data", rsp_data, 32'hF000_0000);
    wait_idle();

    // Reset in the middle of WAIT
    p_hang = 1'b1;
    req_data_0 = 32'hA5A5_A5A5; req_amt_0 = 5'd7; req_mode_0 = 2'b01;
    req_valid_0 = 1'b1;
    #1;
    g = cyc;
    step();
    req_valid_0 = 1'b0;
    p_hang = 1'b0; p_lat = 1;
    while (cyc < g + 4) step();
    chkb("r039_in_wait", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chkb("r039_busy_zero", busy, 1'b0);
    chk("r039_shf_data_zero", shf_data_in, 32'h0);
    chk("r039_amt_mode_zero", 32'({shf_amount, shf_mode}), 32'h0);
    step(); step();
    rst_n = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (rsp_valid_0 || rsp_valid_1) saw = 1'b1;
    end
    chkb("r039_no_rsp", saw, 1'b0);
    req_data_0 = 32'h0000_0001; req_amt_0 = 5'd31; req_mode_0 = 2'b00;
    req_valid_0 = 1'b1;
    #1;
    chkb("r039_req_ready", req_ready_0, 1'b1);
    g = cyc;
    step();
    req_valid_0 = 1'b0;
    while (cyc < g + 4) step();
    chkb("r039_rsp_valid", rsp_valid_0, 1'b1);
    chk("r039_rsp_data", rsp_data, 32'h8000_0000);
    wait_idle();

    // Randomized traffic
    p_auto = 1'b1; p_noise = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      step();
      rsp_ready_0 = ($urandom % 2 == 0);
      rsp_ready_1 = ($urandom % 3 != 0);
      if (acc0) req_valid_0 = 1'b0;
      if (acc1) req_valid_1 = 1'b0;
      if (!req_valid_0) begin
        if ($urandom % 3 == 0) begin
          req_valid_0 = 1'b1; req_data_0 = $urandom;
          req_amt_0 = 5'($urandom); req_mode_0 = rnd_mode();
        end
      end else if ($urandom % 16 == 0) req_valid_0 = 1'b0;
      if (!req_valid_1) begin
        if ($urandom % 3 == 0) begin
          req_valid_1 = 1'b1; req_data_1 = $urandom;
          req_amt_1 = 5'($urandom); req_mode_1 = rnd_mode();
        end
      end else if ($urandom % 16 == 0) req_valid_1 = 1'b0;
    end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
